vga_timing_align: RTL and testbench
===================================

Name: vga_timing_align

Overview:
- Sits directly downstream of the sync pulse generator.
- Consumes the generator's raw active-low HSync/VSync and re-derives its own column/row position locked to the VSync falling edge.
- Issues pixel-coordinate requests to the pixel source, then re-aligns sync, data-enable and returned RGB so all leave the block in phase for the DAC/pin stage.

Parameters:
TOTAL_COLS, 800, pixels per line including blanking
TOTAL_ROWS, 525, lines per frame including blanking
ACTIVE_COLS, 640, visible pixels per line
ACTIVE_ROWS, 480, visible lines per frame
SYNC_PULSE_HORZ, 96, HSync low width in pixels, starting at column 0
SYNC_PULSE_VERT, 2, VSync low width in lines, starting at row 0
BACK_PORCH_HORZ, 48, pixels between HSync end and first active pixel
BACK_PORCH_VERT, 33, lines between VSync end and first active line
VIDEO_DELAY, 2, pixel-source latency in cycles from o_Req to valid i_Red/i_Grn/i_Blu (min 1)
COLOR_BITS, 3, bits per colour channel

Ports:
i_Clk  in  1  pixel clock
i_Rst  in  1  asynchronous, active-high reset
i_HSync  in  1  raw HSync from sync generator, active low
i_VSync  in  1  raw VSync from sync generator, active low
i_Red  in  COLOR_BITS  pixel-source red, valid VIDEO_DELAY cycles after o_Req
i_Grn  in  COLOR_BITS  pixel-source green
i_Blu  in  COLOR_BITS  pixel-source blue
o_Req  out  1  pixel request; o_X/o_Y valid
o_X  out  10  active-area column, 0..ACTIVE_COLS-1; 0 when o_Req=0
o_Y  out  10  active-area row, 0..ACTIVE_ROWS-1; 0 when o_Req=0
o_Frame_Start  out  1  one-cycle pulse, cycle internal counters load 0,0
o_Locked  out  1  high once the first frame start has been seen
o_HSync  out  1  aligned HSync, active low
o_VSync  out  1  aligned VSync, active low
o_DE  out  1  aligned data enable
o_Red/o_Grn/o_Blu  out  COLOR_BITS each  aligned pixel data; 0 when o_DE=0

Behaviour:
- Reset (async assert, sync release):
  - o_HSync=o_VSync=1; all other outputs 0.
  - Internal counters 0; sync history registers 1; delay lines cleared with syncs at 1.
- Frame detect: r_VSync_Prev registers i_VSync. Frame start when i_VSync=0 and r_VSync_Prev=1.
  - Next cycle: r_Col=0, r_Row=0, o_Frame_Start=1, o_Locked=1. o_Locked stays set until reset.
- Counting otherwise: r_Col increments, wraps at TOTAL_COLS-1 to 0. On wrap, r_Row increments, wraps at TOTAL_ROWS-1 to 0. Width 10 bits.
  - Result: r_Col/r_Row equal the generator column/row delayed 1 cycle.
- Re-sync: a frame start arriving at any position reloads 0,0 unconditionally and pulses o_Frame_Start again. Counting is not blocked.
- Active window:
  - H: r_Col in [SYNC_PULSE_HORZ+BACK_PORCH_HORZ, +ACTIVE_COLS).
  - V: r_Row in [SYNC_PULSE_VERT+BACK_PORCH_VERT, +ACTIVE_ROWS).
  - Defaults: cols 144..783, rows 35..514.
- Request: o_Req registered = o_Locked & inside window. o_X = r_Col-144, o_Y = r_Row-35 (default parameters), registered alongside o_Req. Before lock: o_Req=0.
- Alignment:
  - o_DE is o_Req delayed VIDEO_DELAY+1 cycles.
  - o_Red/o_Grn/o_Blu register i_* when the delayed request is 1, else 0.
  - o_HSync/o_VSync are i_HSync/i_VSync delayed exactly VIDEO_DELAY+2 cycles, passed before lock too.
- Blanking: RGB forced 0 whenever o_DE=0, regardless of i_*.
- Reset mid-frame: everything returns to reset state immediately. Lock reacquired only on the next VSync falling edge.

Optional Feature:
VGA_BORDER_EN
- Defined: pixels with o_X==0, o_X==ACTIVE_COLS-1, o_Y==0 or o_Y==ACTIVE_ROWS-1 output all-ones on every channel, aligned the same as normal data. Other active pixels pass i_*.
- Undefined: all active pixels pass i_*, and no border comparators are built.

Test Plan:
- Reset: assert i_Rst 5 cycles -> o_HSync=o_VSync=1; o_DE=o_Req=o_Locked=0; RGB 0. Async: outputs change before the next clock edge.
- Lock: generator VSync/HSync fall at cycle T (col 0,row 0) -> o_Frame_Start=1 and o_Locked=1 at T+1; o_HSync falls at T+4 (VIDEO_DELAY=2).
- First pixel: continue from T -> o_Req=1, o_X=0, o_Y=0 at T+28145 (35*800+144+1). o_DE=1 at T+28148 with o_Red equal to i_Red sampled at T+28147. Last request of line 0 at o_X=639; o_DE low for the following 160 cycles.
- Blanking: drive i_Red=i_Grn=i_Blu=7 constantly for a full frame -> RGB 0 whenever o_DE=0. Exactly 640*480 o_DE-high cycles per frame.
- Re-sync: inject a VSync falling edge at row 200 -> counters reload, o_Frame_Start pulses, next o_Req at +28144 cycles with o_X=0, o_Y=0.
- VGA_BORDER_EN: i_*=0 -> all-ones at o_X=0/639 on every active line and across whole lines o_Y=0/479; zero elsewhere. With macro undefined, all zero.

Source files
------------

// File: rtl/vga_timing_align.sv
// Re-derives column/row from the raw sync stream, issues pixel requests and re-aligns
// sync, data enable and returned RGB. Optional border overlay: define VGA_BORDER_EN.
module vga_timing_align #(
  parameter int unsigned TOTAL_COLS      = 800,
  parameter int unsigned TOTAL_ROWS      = 525,
  parameter int unsigned ACTIVE_COLS     = 640,
  parameter int unsigned ACTIVE_ROWS     = 480,
  parameter int unsigned SYNC_PULSE_HORZ = 96,
  parameter int unsigned SYNC_PULSE_VERT = 2,
  parameter int unsigned BACK_PORCH_HORZ = 48,
  parameter int unsigned BACK_PORCH_VERT = 33,
  parameter int unsigned VIDEO_DELAY     = 2,
  parameter int unsigned COLOR_BITS      = 3
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst,
  input  logic                  i_HSync,
  input  logic                  i_VSync,
  input  logic [COLOR_BITS-1:0] i_Red,
  input  logic [COLOR_BITS-1:0] i_Grn,
  input  logic [COLOR_BITS-1:0] i_Blu,
  output logic                  o_Req,
  output logic [9:0]            o_X,
  output logic [9:0]            o_Y,
  output logic                  o_Frame_Start,
  output logic                  o_Locked,
  output logic                  o_HSync,
  output logic                  o_VSync,
  output logic                  o_DE,
  output logic [COLOR_BITS-1:0] o_Red,
  output logic [COLOR_BITS-1:0] o_Grn,
  output logic [COLOR_BITS-1:0] o_Blu
);

  localparam int unsigned HStart   = SYNC_PULSE_HORZ + BACK_PORCH_HORZ;
  localparam int unsigned VStart   = SYNC_PULSE_VERT + BACK_PORCH_VERT;
  localparam int unsigned SyncLen  = VIDEO_DELAY + 2;

  localparam logic [9:0] ColLast   = 10'(TOTAL_COLS - 1);
  localparam logic [9:0] RowLast   = 10'(TOTAL_ROWS - 1);
  localparam logic [9:0] HStartC   = 10'(HStart);
  localparam logic [9:0] HEndC     = 10'(HStart + ACTIVE_COLS);
  localparam logic [9:0] VStartC   = 10'(VStart);
  localparam logic [9:0] VEndC     = 10'(VStart + ACTIVE_ROWS);

  // ---------------------------------------------------------------------------
  // Frame detect and position counters
  // ---------------------------------------------------------------------------
  logic       vsync_prev_d, vsync_prev_q;
  logic       frame_start;
  logic [9:0] col_d, col_q;
  logic [9:0] row_d, row_q;
  logic       locked_d, locked_q;
  logic       fs_d, fs_q;

  always_comb begin
    vsync_prev_d = i_VSync;
    frame_start  = ~i_VSync & vsync_prev_q;
    fs_d         = frame_start;
    locked_d     = locked_q | frame_start;
    col_d        = col_q + 10'd1;
    row_d        = row_q;
    if (frame_start) begin
      // A falling VSync edge always wins, wherever the counters happen to be.
      col_d = '0;
      row_d = '0;
    end else if (col_q == ColLast) begin
      col_d = '0;
      row_d = (row_q == RowLast) ? 10'd0 : row_q + 10'd1;
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      vsync_prev_q <= 1'b1;
      col_q        <= '0;
      row_q        <= '0;
      locked_q     <= 1'b0;
      fs_q         <= 1'b0;
    end else begin
      vsync_prev_q <= vsync_prev_d;
      col_q        <= col_d;
      row_q        <= row_d;
      locked_q     <= locked_d;
      fs_q         <= fs_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Pixel request, registered alongside the counters so it tracks col_q/row_q
  // ---------------------------------------------------------------------------
  logic       h_active, v_active;
  logic       req_d, req_q;
  logic [9:0] x_d, x_q;
  logic [9:0] y_d, y_q;

  always_comb begin
    h_active = (col_d >= HStartC) && (col_d < HEndC);
    v_active = (row_d >= VStartC) && (row_d < VEndC);
    req_d    = locked_d & h_active & v_active;
    x_d      = '0;
    y_d      = '0;
    if (req_d) begin
      x_d = col_d - HStartC;
      y_d = row_d - VStartC;
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      req_q <= 1'b0;
      x_q   <= '0;
      y_q   <= '0;
    end else begin
      req_q <= req_d;
      x_q   <= x_d;
      y_q   <= y_d;
    end
  end

`ifdef VGA_BORDER_EN
  localparam logic [9:0] XLast = 10'(ACTIVE_COLS - 1);
  localparam logic [9:0] YLast = 10'(ACTIVE_ROWS - 1);

  logic                   border_d, border_q;
  logic [VIDEO_DELAY-1:0] border_pipe_d, border_pipe_q;

  always_comb begin
    border_d = req_d && ((x_d == 10'd0) || (x_d == XLast) ||
                         (y_d == 10'd0) || (y_d == YLast));
    border_pipe_d[0] = border_q;
    for (int i = 1; i < int'(VIDEO_DELAY); i++) begin
      border_pipe_d[i] = border_pipe_q[i-1];
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      border_q      <= 1'b0;
      border_pipe_q <= '0;
    end else begin
      border_q      <= border_d;
      border_pipe_q <= border_pipe_d;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Alignment: request delayed to meet returning pixel data, syncs delayed to match
  // ---------------------------------------------------------------------------
  logic [VIDEO_DELAY-1:0] req_pipe_d, req_pipe_q;
  logic                   pix_valid;
  logic                   de_d, de_q;
  logic [COLOR_BITS-1:0]  red_d, red_q;
  logic [COLOR_BITS-1:0]  grn_d, grn_q;
  logic [COLOR_BITS-1:0]  blu_d, blu_q;
  logic [SyncLen-1:0]     hs_pipe_d, hs_pipe_q;
  logic [SyncLen-1:0]     vs_pipe_d, vs_pipe_q;

  always_comb begin
    req_pipe_d[0] = req_q;
    for (int i = 1; i < int'(VIDEO_DELAY); i++) begin
      req_pipe_d[i] = req_pipe_q[i-1];
    end
    pix_valid = req_pipe_q[VIDEO_DELAY-1];
    de_d      = pix_valid;
    red_d     = '0;
    grn_d     = '0;
    blu_d     = '0;
    if (pix_valid) begin
      red_d = i_Red;
      grn_d = i_Grn;
      blu_d = i_Blu;
`ifdef VGA_BORDER_EN
      if (border_pipe_q[VIDEO_DELAY-1]) begin
        red_d = '1;
        grn_d = '1;
        blu_d = '1;
      end
`endif
    end
  end

  always_comb begin
    hs_pipe_d[0] = i_HSync;
    vs_pipe_d[0] = i_VSync;
    for (int i = 1; i < int'(SyncLen); i++) begin
      hs_pipe_d[i] = hs_pipe_q[i-1];
      vs_pipe_d[i] = vs_pipe_q[i-1];
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      req_pipe_q <= '0;
      de_q       <= 1'b0;
      red_q      <= '0;
      grn_q      <= '0;
      blu_q      <= '0;
      hs_pipe_q  <= '1;
      vs_pipe_q  <= '1;
    end else begin
      req_pipe_q <= req_pipe_d;
      de_q       <= de_d;
      red_q      <= red_d;
      grn_q      <= grn_d;
      blu_q      <= blu_d;
      hs_pipe_q  <= hs_pipe_d;
      vs_pipe_q  <= vs_pipe_d;
    end
  end

  assign o_Req         = req_q;
  assign o_X           = x_q;
  assign o_Y           = y_q;
  assign o_Frame_Start = fs_q;
  assign o_Locked      = locked_q;
  assign o_HSync       = hs_pipe_q[SyncLen-1];
  assign o_VSync       = vs_pipe_q[SyncLen-1];
  assign o_DE          = de_q;
  assign o_Red         = red_q;
  assign o_Grn         = grn_q;
  assign o_Blu         = blu_q;

endmodule

// File: tb/tb_vga_timing_align.sv
// Randomised scoreboard bench for vga_timing_align on a shrunken frame geometry.
module tb_vga_timing_align;

  localparam int TC = 20, TR = 12, AC = 8, AR = 5;
  localparam int SH = 3, SV = 2, BH = 4, BV = 3, VD = 2, CB = 3;
  localparam int FRAME = TC * TR;
  localparam int HS0 = SH + BH, VS0 = SV + BV;
  localparam int NCYC = 2400;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          hs_i = 1'b1, vs_i = 1'b1;
  logic [CB-1:0] red_i = '0, grn_i = '0, blu_i = '0;
  logic          req_o, fs_o, lock_o, hs_o, vs_o, de_o;
  logic [9:0]    x_o, y_o;
  logic [CB-1:0] red_o, grn_o, blu_o;

  vga_timing_align #(
    .TOTAL_COLS(TC), .TOTAL_ROWS(TR), .ACTIVE_COLS(AC), .ACTIVE_ROWS(AR),
    .SYNC_PULSE_HORZ(SH), .SYNC_PULSE_VERT(SV), .BACK_PORCH_HORZ(BH),
    .BACK_PORCH_VERT(BV), .VIDEO_DELAY(VD), .COLOR_BITS(CB)
  ) dut (
    .i_Clk(clk), .i_Rst(rst), .i_HSync(hs_i), .i_VSync(vs_i),
    .i_Red(red_i), .i_Grn(grn_i), .i_Blu(blu_i),
    .o_Req(req_o), .o_X(x_o), .o_Y(y_o), .o_Frame_Start(fs_o), .o_Locked(lock_o),
    .o_HSync(hs_o), .o_VSync(vs_o), .o_DE(de_o),
    .o_Red(red_o), .o_Grn(grn_o), .o_Blu(blu_o)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; int x; int y; } req_t;
  typedef struct { int cyc; logic [3*CB-1:0] rgb; } pix_t;

  req_t req_sb[$];
  pix_t pix_sb[$];
  int   checks = 0, failures = 0;
  int   cyc = -1;
  bit   hs_hist[NCYC+1], vs_hist[NCYC+1], rst_hist[NCYC+1];
  bit   e_fs[NCYC+1], e_lock[NCYC+1], req_at[NCYC+1];
  int   rx[NCYC+1], ry[NCYC+1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  // Driver + reference model: internal position is the distance from the last
  // detected VSync falling edge, taken modulo the frame length.
  initial begin
    int gc, gr, prev_vs, locked, s_cyc, last_rst, p, col, row;
    bit r, h, v, fs, blank7;
    logic [3*CB-1:0] d;
    gc = 3; gr = 8; prev_vs = 1; locked = 0; s_cyc = -1; last_rst = -1;
    for (int k = 0; k < NCYC; k++) begin
      @(posedge clk);
      #1;
      cyc = k;
      r = (k < 5) || (k >= 1500 && k < 1503);
      if (k == 700) begin gc = 0; gr = 0; end
      if (k == 1000 || k == 1250 || k == 1900) begin
        gc = $urandom_range(TC - 1);
        gr = $urandom_range(TR - 1);
      end
      blank7 = (k >= 300 && k < 300 + FRAME);
      h = (gc >= SH);
      v = (gr >= SV);
      d = blank7 ? {3*CB{1'b1}} : 3*CB'($urandom);
      rst = r; hs_i = h; vs_i = v;
      {red_i, grn_i, blu_i} = d;
      hs_hist[k] = h; vs_hist[k] = v; rst_hist[k] = r;
      if (r) begin
        req_sb.delete();
        pix_sb.delete();
        last_rst = k; prev_vs = 1; locked = 0; s_cyc = -1;
        e_fs[k+1] = 0; e_lock[k+1] = 0;
      end else begin
        fs = (v == 0) && (prev_vs == 1);
        prev_vs = v;
        if (fs) begin s_cyc = k; locked = 1; end
        e_fs[k+1] = fs;
        e_lock[k+1] = locked[0];
        if (locked != 0) begin
          p = (k - s_cyc) % FRAME;
          col = p % TC;
          row = p / TC;
          if (col >= HS0 && col < HS0 + AC && row >= VS0 && row < VS0 + AR) begin
            req_sb.push_back('{cyc: k + 1, x: col - HS0, y: row - VS0});
            req_at[k+1] = 1; rx[k+1] = col - HS0; ry[k+1] = row - VS0;
          end
        end
        if (k - VD > last_rst && k - VD >= 0 && req_at[k-VD]) begin
`ifdef VGA_BORDER_EN
          if (rx[k-VD] == 0 || rx[k-VD] == AC - 1 || ry[k-VD] == 0 || ry[k-VD] == AR - 1)
            d = {3*CB{1'b1}};
`endif
          pix_sb.push_back('{cyc: k + 1, rgb: d});
        end
      end
      gc++;
      if (gc == TC) begin
        gc = 0;
        gr = (gr == TR - 1) ? 0 : gr + 1;
      end
    end
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Monitor: samples mid-cycle, pops the scoreboards whenever the DUT presents output.
  int de_cnt = 0, fs_prev = -1, prev_len = -1;
  always @(negedge clk) begin
    if (cyc >= 0) begin
      int m;
      bit ok;
      m = cyc;
      if (rst) begin
        check("reset_ctrl", {hs_o, vs_o, de_o, req_o, lock_o, fs_o}, 6'b110000);
        check("reset_data", {red_o, grn_o, blu_o, x_o, y_o}, '0);
        fs_prev = -1;
        prev_len = -1;
      end else begin
        ok = (m >= VD + 2);
        for (int j = m - (VD + 2); j <= m; j++) if (j >= 0 && rst_hist[j]) ok = 0;
        check("hsync_align", hs_o, ok ? hs_hist[m-VD-2] : 1'b1);
        check("vsync_align", vs_o, ok ? vs_hist[m-VD-2] : 1'b1);
        check("frame_start", fs_o, e_fs[m]);
        check("locked", lock_o, e_lock[m]);
        if (req_o) begin
          if (req_sb.size() == 0) check("req_unexpected", 1, 0);
          else begin
            req_t e;
            e = req_sb.pop_front();
            check("req_cycle", m, e.cyc);
            check("req_x", x_o, e.x);
            check("req_y", y_o, e.y);
          end
        end else begin
          check("idle_xy", {x_o, y_o}, '0);
          if (req_sb.size() > 0 && req_sb[0].cyc <= m) begin
            check("req_missing", 0, 1);
            void'(req_sb.pop_front());
          end
        end
        if (de_o) begin
          de_cnt++;
          if (pix_sb.size() == 0) check("de_unexpected", 1, 0);
          else begin
            pix_t e;
            e = pix_sb.pop_front();
            check("pix_cycle", m, e.cyc);
            check("pix_rgb", {red_o, grn_o, blu_o}, e.rgb);
          end
        end else begin
          check("blank_rgb", {red_o, grn_o, blu_o}, '0);
          if (pix_sb.size() > 0 && pix_sb[0].cyc <= m) begin
            check("de_missing", 0, 1);
            void'(pix_sb.pop_front());
          end
        end
        if (fs_o) begin
          if (fs_prev >= 0 && m - fs_prev == FRAME && prev_len == FRAME)
            check("de_per_frame", de_cnt, AC * AR);
          prev_len = (fs_prev >= 0) ? m - fs_prev : -1;
          fs_prev = m;
          de_cnt = 0;
        end
      end
    end
  end

endmodule
